wb_burst_master: RTL and testbench

- Synthesizable Wishbone B3 registered-feedback burst master for SoC DMA and bridge logic.
- Accepts one command (address, length, direction, burst mode), then runs a classic, constant or incrementing (linear/wrap4/8/16) cycle on the bus.
- Streams write data in and read data out, and returns one response per command.
- Generalises single-beat/burst BFM mastering: parametrised data width and byte lanes, wait states driven by the data stream, retry handling, and a completion status report.

---
 rtl/wb_burst_master_if.sv | 67 ++++++
 rtl/wb_burst_master.sv | 232 +++++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_master_if.sv
// Command, data-stream, response and Wishbone master signals
// of wb_burst_master, with master (DUT) and slave (environment) views.
interface wb_burst_master_if #(
  parameter int aw               = 32,
  parameter int dw               = 32,
  parameter int MAX_BURST_LENGTH = 32
);
  localparam int lw = $clog2(MAX_BURST_LENGTH) + 1;
  localparam int sw = dw / 8;

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [aw-1:0] cmd_adr_i;
  logic [sw-1:0] cmd_sel_i;
  logic [lw-1:0] cmd_len_i;
  logic [1:0]    cmd_mode_i;
  logic [1:0]    cmd_bte_i;

  logic [dw-1:0] wdat_i;
  logic          wdat_valid_i;
  logic          wdat_ready_o;
  logic [dw-1:0] rdat_o;
  logic          rdat_valid_o;

  logic          rsp_valid_o;
  logic          rsp_err_o;
  logic          rsp_rty_o;
  logic [lw-1:0] rsp_beats_o;

  logic [aw-1:0] wb_adr_o;
  logic [dw-1:0] wb_dat_o;
  logic [sw-1:0] wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic [dw-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          wb_rty_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i,
    input  cmd_len_i, cmd_mode_i, cmd_bte_i,
    output cmd_ready_o,
    input  wdat_i, wdat_valid_i,
    output wdat_ready_o, rdat_o, rdat_valid_o,
    output rsp_valid_o, rsp_err_o, rsp_rty_o, rsp_beats_o,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
    output wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i,
    output cmd_len_i, cmd_mode_i, cmd_bte_i,
    input  cmd_ready_o,
    output wdat_i, wdat_valid_i,
    input  wdat_ready_o, rdat_o, rdat_valid_o,
    input  rsp_valid_o, rsp_err_o, rsp_rty_o, rsp_beats_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
    input  wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 registered-feedback burst master (classic/const/incr).
// Define WB_BURST_MASTER_TIMEOUT_EN to add a stalled-strobe watchdog.
module wb_burst_master #(
  parameter int aw               = 32,
  parameter int dw               = 32,
  parameter int MAX_BURST_LENGTH = 32,
  parameter int MAX_RETRY        = 3,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input logic               wb_clk_i,
  input logic               wb_rst_ni,
  wb_burst_master_if.master bus
);
  localparam int lw = $clog2(MAX_BURST_LENGTH) + 1;
  localparam int sw = dw / 8;
  localparam int rw = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [aw-1:0] step = aw'(sw);

  typedef enum logic [1:0] {IDLE, RUN, BACKOFF, RESP} state_t;
  state_t state_q, state_d;

  logic          alive_q;
  logic          we_q;
  logic [aw-1:0] adr_q;
  logic [sw-1:0] sel_q;
  logic [1:0]    mode_q;
  logic [1:0]    bte_q;
  logic [lw-1:0] rem_q;
  logic [lw-1:0] acked_q;
  logic [rw-1:0] retry_q;
  logic          err_q;
  logic          rty_q;
  logic          gap_q;
  logic [dw-1:0] rdat_q;
  logic          rdat_valid_q;

  logic          accept;
  logic          len_ok;
  logic          stb;
  logic          ack;
  logic          err;
  logic          rty;
  logic          last;
  logic          tmo;
  logic [2:0]    cti;
  logic [aw-1:0] wmask;
  logic [aw-1:0] adr_inc;
  logic [aw-1:0] adr_nxt;

  assign accept = (state_q == IDLE) & alive_q & bus.cmd_valid_i;
  assign len_ok = (bus.cmd_len_i != '0) &&
                  (bus.cmd_len_i <= lw'(MAX_BURST_LENGTH));

  // classic cycles idle the strobe for one clock after each ack
  assign stb  = (state_q == RUN) & ~gap_q &
                (~we_q | bus.wdat_valid_i);
  assign err  = stb & bus.wb_err_i;
  assign rty  = stb & bus.wb_rty_i & ~bus.wb_err_i;
  assign ack  = stb & bus.wb_ack_i & ~bus.wb_err_i & ~bus.wb_rty_i;
  assign last = (rem_q == lw'(1));

  always_comb begin
    wmask = '0;
    unique case (bte_q)
      2'd1:    wmask = aw'(4 * sw - 1);
      2'd2:    wmask = aw'(8 * sw - 1);
      2'd3:    wmask = aw'(16 * sw - 1);
      default: wmask = '0;
    endcase
  end

  assign adr_inc = adr_q + step;

  always_comb begin
    adr_nxt = adr_inc;
    unique case (1'b1)
      mode_q == 2'd1:
        adr_nxt = adr_q;
      mode_q == 2'd2 && bte_q != 2'd0:
        adr_nxt = (adr_q & ~wmask) | (adr_inc & wmask);
      default:
        adr_nxt = adr_inc;
    endcase
  end

  always_comb begin
    cti = 3'b000;
    unique case (1'b1)
      mode_q == 2'd1: cti = last ? 3'b111 : 3'b001;
      mode_q == 2'd2: cti = last ? 3'b111 : 3'b010;
      default:        cti = 3'b000;
    endcase
  end

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int tw = $clog2(TIMEOUT_CYCLES + 1);
  logic [tw-1:0] wd_q;
  logic          stall;

  assign stall = stb & ~bus.wb_ack_i & ~bus.wb_err_i & ~bus.wb_rty_i;
  assign tmo   = stall & (wd_q == tw'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wd_q <= '0;
    end else if (state_q != RUN || tmo || (stb && !stall)) begin
      wd_q <= '0;
    end else if (stall) begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  // no watchdog: a silent slave stalls the master indefinitely
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) state_d = len_ok ? RUN : RESP;
      RUN:
        if (err || tmo)       state_d = RESP;
        else if (rty)         state_d = (retry_q != '0) ? BACKOFF : RESP;
        else if (ack && last) state_d = RESP;
      BACKOFF: state_d = RUN;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      alive_q      <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      mode_q       <= '0;
      bte_q        <= '0;
      rem_q        <= '0;
      acked_q      <= '0;
      retry_q      <= '0;
      err_q        <= 1'b0;
      rty_q        <= 1'b0;
      gap_q        <= 1'b0;
      rdat_q       <= '0;
      rdat_valid_q <= 1'b0;
    end else begin
      alive_q      <= 1'b1;
      gap_q        <= 1'b0;
      rdat_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (accept) begin
          we_q    <= bus.cmd_we_i;
          adr_q   <= bus.cmd_adr_i;
          sel_q   <= bus.cmd_sel_i;
          mode_q  <= bus.cmd_mode_i;
          bte_q   <= bus.cmd_bte_i;
          rem_q   <= bus.cmd_len_i;
          acked_q <= '0;
          retry_q <= rw'(MAX_RETRY);
          err_q   <= ~len_ok;
          rty_q   <= 1'b0;
        end
        RUN: begin
          if (err || tmo) begin
            err_q <= 1'b1;
          end else if (rty) begin
            if (retry_q != '0) retry_q <= retry_q - 1'b1;
            else               rty_q   <= 1'b1;
          end else if (ack) begin
            rem_q   <= rem_q - 1'b1;
            acked_q <= acked_q + 1'b1;
            adr_q   <= adr_nxt;
            gap_q   <= (mode_q == 2'd0) & ~last;
            if (!we_q) begin
              rdat_q       <= bus.wb_dat_i;
              rdat_valid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rdat_o       = rdat_q;
  assign bus.rdat_valid_o = rdat_valid_q;

  always_comb begin
    bus.cmd_ready_o  = 1'b0;
    bus.wb_cyc_o     = 1'b0;
    bus.wb_stb_o     = 1'b0;
    bus.wb_we_o      = 1'b0;
    bus.wb_adr_o     = '0;
    bus.wb_sel_o     = '0;
    bus.wb_cti_o     = 3'b000;
    bus.wb_bte_o     = 2'b00;
    bus.wb_dat_o     = '0;
    bus.wdat_ready_o = 1'b0;
    bus.rsp_valid_o  = 1'b0;
    bus.rsp_err_o    = 1'b0;
    bus.rsp_rty_o    = 1'b0;
    bus.rsp_beats_o  = '0;
    unique case (state_q)
      IDLE: bus.cmd_ready_o = alive_q;
      RUN: begin
        bus.wb_cyc_o     = 1'b1;
        bus.wb_stb_o     = stb;
        bus.wb_we_o      = we_q;
        bus.wb_adr_o     = adr_q;
        bus.wb_sel_o     = sel_q;
        bus.wb_cti_o     = cti;
        bus.wb_bte_o     = (mode_q == 2'd2) ? bte_q : 2'b00;
        bus.wb_dat_o     = we_q ? bus.wdat_i : '0;
        bus.wdat_ready_o = ack & we_q;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_err_o   = err_q;
        bus.rsp_rty_o   = rty_q;
        bus.rsp_beats_o = acked_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: scripted Wishbone slave,
// expected beats/read data/responses queued by directed stimulus.
module tb_wb_burst_master;
  localparam int LW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_burst_master_if #(
    .aw(32), .dw(32), .MAX_BURST_LENGTH(32)
  ) bus ();

  wb_burst_master #(
    .aw(32), .dw(32), .MAX_BURST_LENGTH(32),
    .MAX_RETRY(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus)
  );

  assign bus.wb_dat_i = {4'hD, bus.wb_adr_o[27:0]};

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        cc;
    logic [1:0]  bte;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic err;
    logic rty;
    int   beats;
  } rsp_t;

  beat_t       beat_q[$];
  logic [31:0] rdat_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] wq[$];
  int          wgap[$];
  int          script[$];
  int          cyc_rise = 0;
  int          stall    = 0;
  int          rsp_seen = 0;
  logic        cyc_prev = 1'b0;

  function automatic void eb(input logic [31:0] adr, input logic [2:0] cti,
                             input logic cc, input logic [1:0] bte,
                             input logic we, input logic [31:0] dat);
    beat_t b;
    b.adr = adr; b.cti = cti; b.cc = cc;
    b.bte = bte; b.we = we; b.dat = dat;
    beat_q.push_back(b);
  endfunction

  function automatic void er(input logic err, input logic rty, input int n);
    rsp_t r;
    r.err = err; r.rty = rty; r.beats = n;
    rsp_q.push_back(r);
  endfunction

  function automatic void ew(input logic [31:0] d, input int gap);
    wq.push_back(d);
    wgap.push_back(gap);
  endfunction

  // write-data source and scripted slave (0 wait, 1 ack, 2 err, 3 rty)
  always @(negedge clk) begin : slave
    int r;
    if (wq.size() != 0 && wgap[0] > 0) begin
      bus.wdat_valid_i = 1'b0;
      wgap[0] = wgap[0] - 1;
    end else if (wq.size() != 0) begin
      bus.wdat_valid_i = 1'b1;
      bus.wdat_i = wq[0];
    end else begin
      bus.wdat_valid_i = 1'b0;
    end
    #1;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_rty_i = 1'b0;
    if (bus.wb_cyc_o && bus.wb_stb_o) begin
      r = (script.size() != 0) ? script.pop_front() : 1;
      bus.wb_ack_i = (r == 1);
      bus.wb_err_i = (r == 2);
      bus.wb_rty_i = (r == 3);
    end
    #1;
    if (bus.wdat_ready_o && wq.size() != 0) begin
      void'(wq.pop_front());
      void'(wgap.pop_front());
    end
  end

  always @(negedge clk) begin : beat_mon
    beat_t b;
    #3;
    if (bus.wb_cyc_o && !cyc_prev) cyc_rise++;
    cyc_prev = bus.wb_cyc_o;
    if (bus.wb_cyc_o && !bus.wb_stb_o) stall++;
    if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
      checks++;
      if (beat_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected ack adr=%h", bus.wb_adr_o);
      end else begin
        b = beat_q.pop_front();
        if (bus.wb_adr_o !== b.adr || (b.cc && bus.wb_cti_o !== b.cti) ||
            bus.wb_bte_o !== b.bte || bus.wb_we_o !== b.we ||
            bus.wb_sel_o !== 4'hF || (b.we && bus.wb_dat_o !== b.dat)) begin
          errors++;
          $display("FAIL beat: got adr=%h cti=%b bte=%b we=%b dat=%h, need adr=%h cti=%b bte=%b we=%b dat=%h",
                   bus.wb_adr_o, bus.wb_cti_o, bus.wb_bte_o, bus.wb_we_o,
                   bus.wb_dat_o, b.adr, b.cti, b.bte, b.we, b.dat);
        end
      end
    end
  end

  always @(negedge clk) begin : out_mon
    logic [31:0] d;
    rsp_t r;
    if (bus.rdat_valid_o) begin
      checks++;
      if (rdat_q.size() == 0) begin
        errors++;
        $display("FAIL rdat: unexpected beat %h", bus.rdat_o);
      end else begin
        d = rdat_q.pop_front();
        if (bus.rdat_o !== d) begin
          errors++;
          $display("FAIL rdat: got %h need %h", bus.rdat_o, d);
        end
      end
    end
    if (bus.rsp_valid_o) begin
      rsp_seen++;
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp: unexpected response");
      end else begin
        r = rsp_q.pop_front();
        if (bus.rsp_err_o !== r.err || bus.rsp_rty_o !== r.rty ||
            bus.rsp_beats_o !== LW'(r.beats) || bus.wb_cyc_o !== 1'b0) begin
          errors++;
          $display("FAIL rsp: got err=%b rty=%b beats=%0d cyc=%b, need err=%b rty=%b beats=%0d cyc=0",
                   bus.rsp_err_o, bus.rsp_rty_o, bus.rsp_beats_o,
                   bus.wb_cyc_o, r.err, r.rty, r.beats);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] adr, input int len,
                      input logic [1:0] mode, input logic [1:0] bte);
    int n;
    cyc_rise = 0;
    stall    = 0;
    @(negedge clk);
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_sel_i   = 4'hF;
    bus.cmd_len_i   = LW'(len);
    bus.cmd_mode_i  = mode;
    bus.cmd_bte_i   = bte;
    bus.cmd_valid_i = 1'b1;
    n = 0;
    while (!bus.cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL accept: cmd_ready_o=0, need 1 within 100 cycles");
    end
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
  endtask

  task automatic finish_cmd(input string name, input int rise, input int stl);
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || beat_q.size() != 0 || rdat_q.size() != 0)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s drain: left rsp=%0d beats=%0d rdat=%0d, need 0",
               name, rsp_q.size(), beat_q.size(), rdat_q.size());
    end
    checks++;
    if (cyc_rise != rise) begin
      errors++;
      $display("FAIL %s cyc_rise: got %0d need %0d", name, cyc_rise, rise);
    end
    if (stl >= 0) begin
      checks++;
      if (stall != stl) begin
        errors++;
        $display("FAIL %s stall: got %0d need %0d", name, stall, stl);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_we_i     = 1'b0;
    bus.cmd_adr_i    = '0;
    bus.cmd_sel_i    = '0;
    bus.cmd_len_i    = '0;
    bus.cmd_mode_i   = '0;
    bus.cmd_bte_i    = '0;
    bus.wdat_i       = '0;
    bus.wdat_valid_i = 1'b0;
    bus.wb_ack_i     = 1'b0;
    bus.wb_err_i     = 1'b0;
    bus.wb_rty_i     = 1'b0;

    #12;
    checks++;
    if (bus.cmd_ready_o !== 1'b0 || bus.wb_cyc_o !== 1'b0 ||
        bus.wb_stb_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 ||
        bus.rdat_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b cyc=%b stb=%b rsp=%b rdv=%b, need all 0",
               bus.cmd_ready_o, bus.wb_cyc_o, bus.wb_stb_o,
               bus.rsp_valid_o, bus.rdat_valid_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // incrementing linear write
    ew(32'h1111_1111, 0); ew(32'h2222_2222, 0);
    ew(32'h3333_3333, 0); ew(32'h4444_4444, 0);
    eb(32'h100, 3'b010, 1, 2'b00, 1, 32'h1111_1111);
    eb(32'h104, 3'b010, 1, 2'b00, 1, 32'h2222_2222);
    eb(32'h108, 3'b010, 1, 2'b00, 1, 32'h3333_3333);
    eb(32'h10C, 3'b111, 1, 2'b00, 1, 32'h4444_4444);
    er(0, 0, 4);
    send(1, 32'h100, 4, 2'd2, 2'd0);
    finish_cmd("incr_wr", 1, 0);

    // wrap4 read
    eb(32'h10C, 3'b010, 1, 2'b01, 0, 0);
    eb(32'h100, 3'b010, 1, 2'b01, 0, 0);
    eb(32'h104, 3'b010, 1, 2'b01, 0, 0);
    eb(32'h108, 3'b111, 1, 2'b01, 0, 0);
    rdat_q.push_back(32'hD000_010C); rdat_q.push_back(32'hD000_0100);
    rdat_q.push_back(32'hD000_0104); rdat_q.push_back(32'hD000_0108);
    er(0, 0, 4);
    send(0, 32'h10C, 4, 2'd2, 2'd1);
    finish_cmd("wrap4_rd", 1, 0);

    // write with data starved two cycles before beat 2
    ew(32'hAAAA_0001, 0); ew(32'hAAAA_0002, 2); ew(32'hAAAA_0003, 0);
    eb(32'h180, 3'b010, 1, 2'b00, 1, 32'hAAAA_0001);
    eb(32'h184, 3'b010, 1, 2'b00, 1, 32'hAAAA_0002);
    eb(32'h188, 3'b111, 1, 2'b00, 1, 32'hAAAA_0003);
    er(0, 0, 3);
    send(1, 32'h180, 3, 2'd2, 2'd0);
    finish_cmd("starve_wr", 1, 2);

    // read len 8, one retry on beat 3
    script = '{1, 1, 3};
    for (int i = 0; i < 8; i++) begin
      eb(32'h200 + 4 * i, (i == 7) ? 3'b111 : 3'b010, 1, 2'b00, 0, 0);
      rdat_q.push_back(32'hD000_0200 + 4 * i);
    end
    er(0, 0, 8);
    send(0, 32'h200, 8, 2'd2, 2'd0);
    finish_cmd("retry_rd", 2, -1);

    // persistent retry: four attempts then give up
    script = '{3, 3, 3, 3};
    er(0, 1, 0);
    send(0, 32'h300, 2, 2'd2, 2'd0);
    finish_cmd("rty_exh", 4, -1);

    // error on beat 2
    script = '{1, 2};
    eb(32'h400, 3'b010, 1, 2'b00, 0, 0);
    rdat_q.push_back(32'hD000_0400);
    er(1, 0, 1);
    send(0, 32'h400, 4, 2'd2, 2'd0);
    finish_cmd("err_rd", 1, -1);

    // illegal lengths
    er(1, 0, 0);
    send(0, 32'h500, 0, 2'd2, 2'd0);
    finish_cmd("len0", 0, -1);
    er(1, 0, 0);
    send(1, 32'h500, 33, 2'd2, 2'd0);
    finish_cmd("len33", 0, -1);

    // constant-address read
    for (int i = 0; i < 3; i++) begin
      eb(32'h600, (i == 2) ? 3'b111 : 3'b001, 1, 2'b00, 0, 0);
      rdat_q.push_back(32'hD000_0600);
    end
    er(0, 0, 3);
    send(0, 32'h600, 3, 2'd1, 2'd0);
    finish_cmd("const_rd", 1, 0);

    // classic write: strobe gap between beats
    ew(32'h7777_0001, 0); ew(32'h7777_0002, 0);
    eb(32'h700, 3'b000, 0, 2'b00, 1, 32'h7777_0001);
    eb(32'h704, 3'b000, 0, 2'b00, 1, 32'h7777_0002);
    er(0, 0, 2);
    send(1, 32'h700, 2, 2'd0, 2'd0);
    finish_cmd("classic_wr", 1, 1);

    // single-beat incrementing write ends the burst at once
    ew(32'h8888_8888, 0);
    eb(32'h800, 3'b111, 1, 2'b00, 1, 32'h8888_8888);
    er(0, 0, 1);
    send(1, 32'h800, 1, 2'd2, 2'd0);
    finish_cmd("len1_wr", 1, 0);

    // reset mid-burst: bus released at once, no response
    script = '{0, 0, 0, 0, 0, 0, 0, 0};
    seen = rsp_seen;
    send(0, 32'hA00, 4, 2'd2, 2'd0);
    @(posedge clk);
    #2;
    checks++;
    if (bus.wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset cyc: got %b need 1", bus.wb_cyc_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: cyc=%b stb=%b, need 0 0",
               bus.wb_cyc_o, bus.wb_stb_o);
    end
    script.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (rsp_seen != seen) begin
      errors++;
      $display("FAIL reset_rsp: got %0d responses need %0d", rsp_seen, seen);
    end

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    for (int i = 0; i < 24; i++) script.push_back(0);
    er(1, 0, 0);
    send(0, 32'h900, 2, 2'd2, 2'd0);
    finish_cmd("timeout", 1, -1);
    script.delete();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
